// File: rtl/usb_rx_control.sv
// usb_rx_control
// Receive control unit for the USB RX path. Enables the RX bit timer and shift
// register, checks the SYNC byte, writes payload bytes to the RX FIFO and flags
// packet errors (bad SYNC, partial byte at EOP, FIFO full, oversize packet,
// bit timeout).
//
// Optional feature macro: USB_RX_PID_CHECK_EN
//   Defined     : a PID state follows SYNC; the first payload byte must satisfy
//                 rcv_data[7:4] == ~rcv_data[3:0], otherwise the packet errors.
//   Not defined : the first payload byte is plain data.
//
// Ports
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   d_edge         in   1-cycle pulse, line transition detected
//   eop            in   level, end-of-packet (SE0) on line
//   shift_enable   in   1-cycle pulse, bit sampled into shift register
//   byte_received  in   1-cycle pulse, 8 bits assembled
//   rcv_data       in   shift register contents, valid with byte_received
//   fifo_full      in   RX FIFO cannot accept a write
//   receiving      out  enables RX timer/shift register
//   w_enable       out  1-cycle FIFO write strobe
//   w_data         out  FIFO write data
//   byte_count     out  payload bytes stored this packet
//   rcv_error      out  sticky packet error
//   packet_done    out  1-cycle pulse, packet received cleanly
//
// State      | meaning
// IDLE       | bus idle, waiting for the first line transition
// SYNC       | receiving the SYNC byte
// PID        | receiving the PID byte (USB_RX_PID_CHECK_EN only)
// DATA       | receiving payload bytes
// STORE      | one-cycle FIFO write of the byte just received
// EOP_WAIT   | SE0 seen on a byte boundary, waiting for return to J
// DONE       | one-cycle clean-packet pulse
// ERR        | packet error, waiting for eop low and a line transition
module usb_rx_control #(
  parameter int          MAX_BYTES      = 64,
  parameter logic [7:0]  SYNC_BYTE      = 8'h80,
  parameter int          TIMEOUT_CYCLES = 100
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             d_edge,
  input  logic                             eop,
  input  logic                             shift_enable,
  input  logic                             byte_received,
  input  logic [7:0]                       rcv_data,
  input  logic                             fifo_full,
  output logic                             receiving,
  output logic                             w_enable,
  output logic [7:0]                       w_data,
  output logic [$clog2(MAX_BYTES+1)-1:0]   byte_count,
  output logic                             rcv_error,
  output logic                             packet_done
);

  localparam int CNT_W = $clog2(MAX_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STORE,
    EOP_WAIT,
    DONE,
    ERR
`ifdef USB_RX_PID_CHECK_EN
    , PID
`endif
  } state_t;

  state_t          state;
  logic [2:0]      bit_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            eop_pend;

  logic            to_hit;
  logic            at_max;
  logic            bad_byte;

  // The timeout fires on the cycle that would make the idle count reach
  // TIMEOUT_CYCLES, i.e. the TIMEOUT_CYCLES-th consecutive cycle without a bit.
  assign to_hit = !shift_enable && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
  assign at_max = (byte_count == CNT_W'(MAX_BYTES));

`ifdef USB_RX_PID_CHECK_EN
  logic pid_ok;
  assign pid_ok   = (rcv_data[7:4] == ~rcv_data[3:0]);
  assign bad_byte = fifo_full || at_max || ((state == PID) && !pid_ok);
`else
  assign bad_byte = fifo_full || at_max;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      eop_pend    <= 1'b0;
      receiving   <= 1'b0;
      w_enable    <= 1'b0;
      w_data      <= '0;
      byte_count  <= '0;
      rcv_error   <= 1'b0;
      packet_done <= 1'b0;
    end else begin
      w_enable    <= 1'b0;
      packet_done <= 1'b0;
      case (state)
        IDLE: begin
          if (d_edge) begin
            state      <= SYNC;
            receiving  <= 1'b1;
            byte_count <= '0;
            rcv_error  <= 1'b0;
            bit_cnt    <= '0;
            to_cnt     <= '0;
            eop_pend   <= 1'b0;
          end
        end
        SYNC: begin
          to_cnt <= shift_enable ? '0 : to_cnt + 1'b1;
          if (byte_received && (rcv_data == SYNC_BYTE)) begin
`ifdef USB_RX_PID_CHECK_EN
            state <= PID;
`else
            state <= DATA;
`endif
          end else if (byte_received || eop || to_hit) begin
            state     <= ERR;
            receiving <= 1'b0;
            rcv_error <= 1'b1;
          end
        end
`ifdef USB_RX_PID_CHECK_EN
        PID,
`endif
        DATA: begin
          to_cnt <= shift_enable ? '0 : to_cnt + 1'b1;
          if (shift_enable)
            bit_cnt <= bit_cnt + 1'b1;
          if (byte_received) begin
            // The byte wins over a coincident eop; eop_pend carries it to STORE.
            bit_cnt <= '0;
            w_data  <= rcv_data;
            if (bad_byte) begin
              state     <= ERR;
              receiving <= 1'b0;
              rcv_error <= 1'b1;
            end else begin
              state    <= STORE;
              w_enable <= 1'b1;
              eop_pend <= eop;
            end
          end else if (eop && (bit_cnt == 3'd0)) begin
            state     <= EOP_WAIT;
            receiving <= 1'b0;
          end else if (eop || to_hit) begin
            state     <= ERR;
            receiving <= 1'b0;
            rcv_error <= 1'b1;
          end
        end
        STORE: begin
          if (!at_max)
            byte_count <= byte_count + 1'b1;
          eop_pend <= 1'b0;
          if (eop_pend || eop) begin
            state     <= EOP_WAIT;
            receiving <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        EOP_WAIT: begin
          if (d_edge) begin
            state       <= DONE;
            packet_done <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ERR: begin
          if (d_edge && !eop)
            state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          receiving <= 1'b0;
        end
      endcase
    end
  end

endmodule
